register_file_mp: RTL and testbench

//  Parametrised multi-port register file with an instruction pointer (IP), for the glasscell core.
//  - Adds N read ports, M write ports, a configurable IP step and stall, and a per-register busy scoreboard.
//  - Sits between decode (reads, issue) and writeback (writes); drives the fetch address.

---
 rtl/register_file_mp_pkg.sv | 29 ++
 rtl/register_file_mp_if.sv | 33 +++
 rtl/register_file_mp_scoreboard.sv | 80 ++++++++
 rtl/register_file_mp.sv | 114 +++++++++++
 tb/tb_register_file_mp.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/register_file_mp_pkg.sv
// Shared types, constants and write-port priority helper for the glasscell register file.
// Optional same-cycle read bypass is enabled with the REGFILE_BYPASS_EN macro.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_NUM_REGS     = 16;
  localparam int ADDR_W           = $clog2(DEF_NUM_REGS);
  localparam int ZERO_REG         = 0;
  localparam int IP_INDEX_DEFAULT = 15;
  localparam int MAX_PORTS        = 8;

  typedef logic [ADDR_W-1:0]         reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

  // Highest-index set bit of a per-port match vector, -1 when no port matches.
  function automatic int write_winner(input logic [MAX_PORTS-1:0] match);
    int win;
    win = -1;
    for (int p = 0; p < MAX_PORTS; p++) begin
      if (match[p]) begin
        win = p;
      end else begin
        win = win;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Decode/writeback/fetch bundle of the multi-port register file.
interface register_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2
);
  localparam int ADDR_BITS = $clog2(NUM_REGS);

  logic                            ActiveMode;
  logic                            Stall;
  logic [NUM_READ*ADDR_BITS-1:0]   ReadAddress;
  logic [NUM_READ*DATA_WIDTH-1:0]  ReadData;
  logic [NUM_READ-1:0]             ReadBusy;
  logic [NUM_WRITE-1:0]            WriteEnable;
  logic [NUM_WRITE*ADDR_BITS-1:0]  WriteAddress;
  logic [NUM_WRITE*DATA_WIDTH-1:0] WriteData;
  logic                            IssueValid;
  logic [ADDR_BITS-1:0]            IssueAddress;
  logic [DATA_WIDTH-1:0]           InstructionPointerOut;

  modport master (
    output ActiveMode, Stall, ReadAddress, WriteEnable, WriteAddress, WriteData,
           IssueValid, IssueAddress,
    input  ReadData, ReadBusy, InstructionPointerOut
  );

  modport slave (
    input  ActiveMode, Stall, ReadAddress, WriteEnable, WriteAddress, WriteData,
           IssueValid, IssueAddress,
    output ReadData, ReadBusy, InstructionPointerOut
  );
endinterface

// File: rtl/register_file_mp_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, set wins on collision.
// REGFILE_BYPASS_EN makes lookups of written addresses show the post-write state.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 2,
  parameter int ADDR_BITS = $clog2(NUM_REGS)
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic                           issue_valid,
  input  logic [ADDR_BITS-1:0]           issue_addr,
  input  logic [NUM_WRITE-1:0]           write_en,
  input  logic [NUM_WRITE*ADDR_BITS-1:0] write_addr,
  input  logic [NUM_READ*ADDR_BITS-1:0]  read_addr,
  output logic [NUM_READ-1:0]            read_busy
);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] set_s;
  logic [NUM_REGS-1:0] clr_s;
  logic [NUM_REGS-1:0] busy_next_s;

  // Next busy state per register with set-over-clear priority
  always_comb begin
    logic clr;
    clr         = 1'b0;
    set_s       = '0;
    clr_s       = '0;
    busy_next_s = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      clr = 1'b0;
      for (int p = 0; p < NUM_WRITE; p++) begin
        clr = clr | (write_en[p] && (write_addr[p*ADDR_BITS +: ADDR_BITS] == ADDR_BITS'(r)));
      end
      set_s[r] = issue_valid && (issue_addr == ADDR_BITS'(r));
      clr_s[r] = clr;
      if (r == ZERO_REG) begin
        busy_next_s[r] = 1'b0;
      end else if (set_s[r]) begin
        busy_next_s[r] = 1'b1;
      end else if (clr_s[r]) begin
        busy_next_s[r] = 1'b0;
      end else begin
        busy_next_s[r] = busy_r[r];
      end
    end
  end

  // Busy vector register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Lookup ports
  always_comb begin
    logic [ADDR_BITS-1:0] a;
    a         = '0;
    read_busy = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      a = read_addr[i*ADDR_BITS +: ADDR_BITS];
`ifdef REGFILE_BYPASS_EN
      if (clr_s[a]) begin
        read_busy[i] = busy_next_s[a];
      end else begin
        read_busy[i] = busy_r[a];
      end
`else
      read_busy[i] = busy_r[a];
`endif
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with instruction pointer and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int                   DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int                   NUM_REGS     = DEF_NUM_REGS,
  parameter int                   NUM_READ     = 2,
  parameter int                   NUM_WRITE    = 2,
  parameter int                   IP_INDEX     = IP_INDEX_DEFAULT,
  parameter int                   IP_STEP      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic               Clock,
  input logic               Reset,
  register_file_mp_if.slave bus
);

  localparam int ADDR_BITS = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs_r    [NUM_REGS];
  logic [DATA_WIDTH-1:0] wr_data_s [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_hit_s;
  logic                  ip_advance_s;

  // Winning write port and its data for every register; register 0 is never written
  always_comb begin
    logic [MAX_PORTS-1:0] match;
    int                   win;
    match    = '0;
    win      = -1;
    wr_hit_s = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      match = '0;
      for (int p = 0; p < NUM_WRITE; p++) begin
        match[p] = bus.WriteEnable[p] &&
                   (bus.WriteAddress[p*ADDR_BITS +: ADDR_BITS] == ADDR_BITS'(r));
      end
      win = write_winner(match);
      if ((win >= 0) && (r != ZERO_REG)) begin
        wr_hit_s[r]  = 1'b1;
        wr_data_s[r] = bus.WriteData[win*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        wr_hit_s[r]  = 1'b0;
        wr_data_s[r] = '0;
      end
    end
  end

  // A write to the IP replaces the increment for that cycle
  always_comb begin
    ip_advance_s = bus.ActiveMode && !bus.Stall && !wr_hit_s[IP_INDEX];
  end

  // Storage array including the IP register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r] <= (r == IP_INDEX) ? RESET_VECTOR : '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_hit_s[r]) begin
          regs_r[r] <= wr_data_s[r];
        end else if ((r == IP_INDEX) && (r != ZERO_REG) && ip_advance_s) begin
          regs_r[r] <= regs_r[r] + DATA_WIDTH'(IP_STEP);
        end else begin
          regs_r[r] <= regs_r[r];
        end
      end
    end
  end

  // Zero-latency read ports
  always_comb begin
    logic [ADDR_BITS-1:0]  a;
    logic [DATA_WIDTH-1:0] d;
    a            = '0;
    d            = '0;
    bus.ReadData = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      a = bus.ReadAddress[i*ADDR_BITS +: ADDR_BITS];
      if (a == ADDR_BITS'(ZERO_REG)) begin
        d = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_hit_s[a]) begin
        d = wr_data_s[a];
`endif
      end else begin
        d = regs_r[a];
      end
      bus.ReadData[i*DATA_WIDTH +: DATA_WIDTH] = d;
    end
  end

  assign bus.InstructionPointerOut = regs_r[IP_INDEX];

  regfile_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .NUM_READ  (NUM_READ),
    .NUM_WRITE (NUM_WRITE),
    .ADDR_BITS (ADDR_BITS)
  ) u_scoreboard (
    .Clock       (Clock),
    .Reset       (Reset),
    .issue_valid (bus.IssueValid),
    .issue_addr  (bus.IssueAddress),
    .write_en    (bus.WriteEnable),
    .write_addr  (bus.WriteAddress),
    .read_addr   (bus.ReadAddress),
    .read_busy   (bus.ReadBusy)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed self-checking bench for register_file_mp (default build, or with REGFILE_BYPASS_EN).
module tb_register_file_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic Clock;
  logic Reset;
  int   tests = 0;
  int   fails = 0;

  register_file_mp_if #(.DATA_WIDTH(32), .NUM_REGS(16), .NUM_READ(2), .NUM_WRITE(2)) bus ();

  register_file_mp dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_ports();
    bus.WriteEnable  = 2'b00;
    bus.WriteAddress = 8'h00;
    bus.WriteData    = 64'h0;
    bus.IssueValid   = 1'b0;
    bus.IssueAddress = 4'h0;
  endtask

  task automatic set_write(input int port, input logic [3:0] a, input logic [31:0] d);
    bus.WriteEnable[port]         = 1'b1;
    bus.WriteAddress[port*4 +: 4] = a;
    bus.WriteData[port*32 +: 32]  = d;
  endtask

  task automatic set_read(input logic [3:0] a0, input logic [3:0] a1);
    bus.ReadAddress = {a1, a0};
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.ActiveMode = 1'b0;
    bus.Stall = 1'b0;
    clear_ports();
    set_read(4'd3, 4'd15);
    tick();
    tick();
    Reset = 1'b0;
    #1;
    tests++; if (bus.InstructionPointerOut !== 32'h0) begin fails++; $display("FAIL reset_ip: got %h want %h", bus.InstructionPointerOut, 32'h0); end
    tests++; if (bus.ReadData !== 64'h0) begin fails++; $display("FAIL reset_read: got %h want %h", bus.ReadData, 64'h0); end
    tests++; if (bus.ReadBusy !== 2'b00) begin fails++; $display("FAIL reset_busy: got %b want %b", bus.ReadBusy, 2'b00); end
  endtask

  task automatic test_ip_advance();
    bus.ActiveMode = 1'b1;
    #1;
    tests++; if (bus.InstructionPointerOut !== 32'h0) begin fails++; $display("FAIL ip_start: got %h want %h", bus.InstructionPointerOut, 32'h0); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      tests++; if (bus.InstructionPointerOut !== 32'(4*k)) begin fails++; $display("FAIL ip_advance%0d: got %h want %h", k, bus.InstructionPointerOut, 32'(4*k)); end
    end
    bus.Stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests++; if (bus.InstructionPointerOut !== 32'd12) begin fails++; $display("FAIL ip_stall%0d: got %h want %h", k, bus.InstructionPointerOut, 32'd12); end
    end
    bus.Stall = 1'b0;
    bus.ActiveMode = 1'b0;
  endtask

  task automatic test_write_priority();
    set_write(0, 4'd3, 32'hAAAA_0000);
    set_write(1, 4'd3, 32'h5555_0000);
    tick();
    clear_ports();
    set_read(4'd3, 4'd3);
    tests++; if (bus.ReadData[31:0] !== 32'h5555_0000) begin fails++; $display("FAIL wr_priority: got %h want %h", bus.ReadData[31:0], 32'h5555_0000); end
    set_write(0, 4'd4, 32'h0000_0011);
    set_write(1, 4'd6, 32'h0000_0022);
    tick();
    clear_ports();
    set_read(4'd4, 4'd6);
    tests++; if (bus.ReadData[31:0] !== 32'h11) begin fails++; $display("FAIL wr_dual_p0: got %h want %h", bus.ReadData[31:0], 32'h11); end
    tests++; if (bus.ReadData[63:32] !== 32'h22) begin fails++; $display("FAIL wr_dual_p1: got %h want %h", bus.ReadData[63:32], 32'h22); end
  endtask

  task automatic test_reg0();
    set_write(1, 4'd0, 32'hDEAD_BEEF);
    bus.IssueValid = 1'b1;
    bus.IssueAddress = 4'd0;
    tick();
    clear_ports();
    set_read(4'd0, 4'd3);
    tests++; if (bus.ReadData[31:0] !== 32'h0) begin fails++; $display("FAIL reg0_data: got %h want %h", bus.ReadData[31:0], 32'h0); end
    tests++; if (bus.ReadBusy[0] !== 1'b0) begin fails++; $display("FAIL reg0_busy: got %b want %b", bus.ReadBusy[0], 1'b0); end
  endtask

  task automatic test_ip_write();
    bus.ActiveMode = 1'b1;
    set_write(0, 4'd15, 32'h0000_0100);
    tick();
    clear_ports();
    bus.ActiveMode = 1'b0;
    #1;
    tests++; if (bus.InstructionPointerOut !== 32'h100) begin fails++; $display("FAIL ip_write: got %h want %h", bus.InstructionPointerOut, 32'h100); end
    bus.ActiveMode = 1'b1;
    set_write(0, 4'd15, 32'h0000_0200);
    set_write(1, 4'd15, 32'h0000_0300);
    tick();
    clear_ports();
    bus.ActiveMode = 1'b0;
    #1;
    tests++; if (bus.InstructionPointerOut !== 32'h300) begin fails++; $display("FAIL ip_write_prio: got %h want %h", bus.InstructionPointerOut, 32'h300); end
    set_write(1, 4'd15, 32'hFFFF_FFFC);
    tick();
    clear_ports();
    set_read(4'd15, 4'd0);
    tests++; if (bus.ReadData[31:0] !== 32'hFFFF_FFFC) begin fails++; $display("FAIL ip_read: got %h want %h", bus.ReadData[31:0], 32'hFFFF_FFFC); end
    bus.ActiveMode = 1'b1;
    tick();
    bus.ActiveMode = 1'b0;
    #1;
    tests++; if (bus.InstructionPointerOut !== 32'h0) begin fails++; $display("FAIL ip_wrap: got %h want %h", bus.InstructionPointerOut, 32'h0); end
  endtask

  task automatic test_scoreboard();
    set_read(4'd5, 4'd15);
    bus.IssueValid = 1'b1;
    bus.IssueAddress = 4'd5;
    tick();
    clear_ports();
    tests++; if (bus.ReadBusy[0] !== 1'b1) begin fails++; $display("FAIL sb_issue: got %b want %b", bus.ReadBusy[0], 1'b1); end
    set_write(0, 4'd5, 32'h55);
    tick();
    clear_ports();
    tests++; if (bus.ReadBusy[0] !== 1'b0) begin fails++; $display("FAIL sb_clear: got %b want %b", bus.ReadBusy[0], 1'b0); end
    bus.IssueValid = 1'b1;
    bus.IssueAddress = 4'd5;
    set_write(1, 4'd5, 32'h66);
    tick();
    clear_ports();
    #1;
    tests++; if (bus.ReadBusy[0] !== 1'b1) begin fails++; $display("FAIL sb_set_wins: got %b want %b", bus.ReadBusy[0], 1'b1); end
    tests++; if (bus.ReadData[31:0] !== 32'h66) begin fails++; $display("FAIL sb_wdata: got %h want %h", bus.ReadData[31:0], 32'h66); end
    set_write(0, 4'd5, 32'h77);
    #1;
    tests++; if (bus.ReadBusy[0] !== !BYP) begin fails++; $display("FAIL sb_same_cycle: got %b want %b", bus.ReadBusy[0], !BYP); end
    tick();
    clear_ports();
    bus.IssueValid = 1'b1;
    bus.IssueAddress = 4'd15;
    tick();
    clear_ports();
    #1;
    tests++; if (bus.ReadBusy !== 2'b10) begin fails++; $display("FAIL sb_ip_busy: got %b want %b", bus.ReadBusy, 2'b10); end
  endtask

  task automatic test_bypass();
    set_write(1, 4'd7, 32'h9999);
    tick();
    clear_ports();
    set_write(0, 4'd0, 32'hFFFF);
    set_write(1, 4'd7, 32'h1234);
    set_read(4'd7, 4'd0);
    tests++; if (bus.ReadData[31:0] !== (BYP ? 32'h1234 : 32'h9999)) begin fails++; $display("FAIL bypass_r7: got %h want %h", bus.ReadData[31:0], (BYP ? 32'h1234 : 32'h9999)); end
    tests++; if (bus.ReadData[63:32] !== 32'h0) begin fails++; $display("FAIL bypass_r0: got %h want %h", bus.ReadData[63:32], 32'h0); end
    tick();
    clear_ports();
    #1;
    tests++; if (bus.ReadData[31:0] !== 32'h1234) begin fails++; $display("FAIL bypass_after: got %h want %h", bus.ReadData[31:0], 32'h1234); end
  endtask

  task automatic test_reset_mid();
    bus.ActiveMode = 1'b1;
    bus.IssueValid = 1'b1;
    bus.IssueAddress = 4'd5;
    set_write(0, 4'd3, 32'hABC);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    bus.ActiveMode = 1'b0;
    clear_ports();
    set_read(4'd3, 4'd5);
    tests++; if (bus.InstructionPointerOut !== 32'h0) begin fails++; $display("FAIL midreset_ip: got %h want %h", bus.InstructionPointerOut, 32'h0); end
    tests++; if (bus.ReadData !== 64'h0) begin fails++; $display("FAIL midreset_data: got %h want %h", bus.ReadData, 64'h0); end
    tests++; if (bus.ReadBusy !== 2'b00) begin fails++; $display("FAIL midreset_busy: got %b want %b", bus.ReadBusy, 2'b00); end
  endtask

  initial begin
    Reset = 1'b1;
    bus.ActiveMode = 1'b0;
    bus.Stall = 1'b0;
    bus.ReadAddress = 8'h00;
    clear_ports();
    test_reset();
    test_ip_advance();
    test_write_priority();
    test_reg0();
    test_ip_write();
    test_scoreboard();
    test_bypass();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
